// File: rtl/i2c_controller_if.sv
// Request/response side of the single-byte I2C controller.
// Latency: none, plain wires between requester and controller.
// Backpressure: requester must hold start only while busy is low; no queuing.
interface i2c_controller_if;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    modport master (output start, addr, rw, wdata, input busy, done, ack_err, rdata);
    modport slave  (input start, addr, rw, wdata, output busy, done, ack_err, rdata);
endinterface

// File: rtl/i2c_controller.sv
// Single-byte I2C initiator: START, address+R/W, one data byte, STOP on open-drain scl/sda.
// Latency: 20 bit periods of 4*CLK_DIV clocks from accept to done, plus sync and stretch time.
// Backpressure: start is ignored while busy; target clock stretching freezes the divider at Q2.
module i2c_controller #(
    parameter int CLK_DIV = 30
) (
    input  logic            clk,
    input  logic            rst,
    i2c_controller_if.slave ctrl,
    inout  wire             scl,
    inout  wire             sda
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_NACK,
        S_STOP
    } state_t;

    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic [6:0]    addr_q;
    logic          rw_q;
    logic [7:0]    wdata_q;
    logic [7:0]    shadow;
    logic [7:0]    rdata_q;
    logic          ack_err_q;
    logic          done_q;
    logic          scl_meta, scl_s;
    logic          sda_meta, sda_s;

    logic       quarter_tick, bit_end, sample, byte_last, stretch_hold;
    logic       accept, tx_bit, scl_low, sda_low;
    logic [7:0] addr_rw;

    assign addr_rw      = {addr_q, rw_q};
    assign quarter_tick = (div_cnt == DIV_LAST);
    assign bit_end      = quarter_tick && (qtr == 2'd3);
    assign sample       = quarter_tick && (qtr == 2'd2);
    assign byte_last    = (bit_cnt == 3'd0);
    // A target holding SCL low as we enter Q2 keeps the divider parked at zero.
    assign stretch_hold = (qtr == 2'd2) && (div_cnt == '0) && !scl_s;
    assign accept       = (state == S_IDLE) && ctrl.start;
    assign tx_bit       = (state == S_ADDR) ? addr_rw[bit_cnt] : wdata_q[bit_cnt];

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

    assign ctrl.busy    = (state != S_IDLE);
    assign ctrl.done    = done_q;
    assign ctrl.ack_err = ack_err_q;
    assign ctrl.rdata   = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_low   = 1'b0;
        sda_low   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl.start) state_nxt = S_START;
            end
            S_START: begin
                sda_low = qtr[1];
                scl_low = (qtr == 2'd3);
                if (bit_end) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                scl_low = !qtr[1];
                sda_low = !tx_bit;
                if (bit_end && byte_last) state_nxt = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                scl_low = !qtr[1];
                if (bit_end) state_nxt = ack_err_q ? S_STOP : (rw_q ? S_READ : S_WRITE);
            end
            S_WRITE: begin
                scl_low = !qtr[1];
                sda_low = !tx_bit;
                if (bit_end && byte_last) state_nxt = S_WRITE_ACK;
            end
            S_WRITE_ACK: begin
                scl_low = !qtr[1];
                if (bit_end) state_nxt = S_STOP;
            end
            S_READ: begin
                scl_low = !qtr[1];
                if (bit_end && byte_last) state_nxt = S_READ_NACK;
            end
            S_READ_NACK: begin
                scl_low = !qtr[1];
                if (bit_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                scl_low = !qtr[1];
                sda_low = (qtr != 2'd3);
                if (bit_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            qtr       <= 2'd0;
            bit_cnt   <= 3'd7;
            addr_q    <= 7'h00;
            rw_q      <= 1'b0;
            wdata_q   <= 8'h00;
            shadow    <= 8'h00;
            rdata_q   <= 8'h00;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            scl_meta  <= 1'b1;
            scl_s     <= 1'b1;
            sda_meta  <= 1'b1;
            sda_s     <= 1'b1;
        end else begin
            scl_meta <= scl;
            scl_s    <= scl_meta;
            sda_meta <= sda;
            sda_s    <= sda_meta;
            done_q   <= 1'b0;
            if (accept) begin
                addr_q    <= ctrl.addr;
                rw_q      <= ctrl.rw;
                wdata_q   <= ctrl.wdata;
                ack_err_q <= 1'b0;
                div_cnt   <= '0;
                qtr       <= 2'd0;
                bit_cnt   <= 3'd7;
            end else if (state != S_IDLE) begin
                if (!stretch_hold) begin
                    if (quarter_tick) begin
                        div_cnt <= '0;
                        qtr     <= qtr + 2'd1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                if (bit_end && (state == S_ADDR || state == S_WRITE || state == S_READ)) begin
                    bit_cnt <= bit_cnt - 3'd1;
                end
                if (sample) begin
                    if ((state == S_ADDR_ACK || state == S_WRITE_ACK) && sda_s) ack_err_q <= 1'b1;
                    if (state == S_READ) shadow <= {shadow[6:0], sda_s};
                end
                if (bit_end && state == S_STOP) begin
                    done_q <= 1'b1;
                    if (rw_q && !ack_err_q) rdata_q <= shadow;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: behavioural I2C target + bus decoder, randomized transactions.
module tb_i2c_controller;

    localparam int CLK_DIV   = 8;
    localparam int BIT_CLKS  = 4 * CLK_DIV;
    localparam int TXN_MIN   = 20 * BIT_CLKS;
    localparam int NACK_MIN  = 11 * BIT_CLKS;
    localparam int SLACK     = 100;
    localparam int LIMIT     = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wire scl;
    wire sda;
    pullup (scl);
    pullup (sda);

    logic tgt_scl_low = 1'b0;
    logic tgt_sda_low = 1'b0;
    assign scl = tgt_scl_low ? 1'b0 : 1'bz;
    assign sda = tgt_sda_low ? 1'b0 : 1'bz;

    i2c_controller_if bus_if ();

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus_if),
        .scl  (scl),
        .sda  (sda)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Target configuration, written only by the stimulus process.
    logic [6:0] tgt_addr      = 7'h00;
    logic       tgt_present   = 1'b0;
    logic       tgt_nack_data = 1'b0;
    logic [7:0] tgt_rdata     = 8'h00;
    int         clr_gen       = 0;

    // Bus decoder / target state, written only by the monitor process.
    logic       cur_scl, cur_sda;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitpos = 0, byte_idx = 0, seen_gen = 0;
    logic [7:0] shreg = 8'h00;
    logic       txn_rw = 1'b0, txn_match = 1'b0;
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];
    int         n_start = 0, n_stop = 0, done_cnt = 0, overlap_cnt = 0;

    // Reference model of the expected bus trace and register outputs.
    logic [7:0] exp_bytes[$];
    logic       exp_acks[$];
    int         exp_starts = 0;
    logic       exp_err    = 1'b0;
    logic [7:0] exp_rdata  = 8'h00;

    always @(negedge clk) begin
        cur_scl = scl;
        cur_sda = sda;
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            mon_bytes.delete();
            mon_acks.delete();
            n_start  = 0;
            n_stop   = 0;
            done_cnt = 0;
        end
        if (bus_if.done) done_cnt++;
        if (bus_if.done && bus_if.busy) overlap_cnt++;
        if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
            n_start++;
            bitpos      = 0;
            byte_idx    = 0;
            tgt_sda_low = 1'b0;
        end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
            n_stop++;
            tgt_sda_low = 1'b0;
        end else if (!prev_scl && cur_scl) begin
            if (bitpos < 8) begin
                shreg = {shreg[6:0], cur_sda};
            end else begin
                mon_bytes.push_back(shreg);
                mon_acks.push_back(cur_sda);
                if (byte_idx == 0) begin
                    txn_rw    = shreg[0];
                    txn_match = tgt_present && (shreg[7:1] == tgt_addr);
                end
                byte_idx++;
            end
            bitpos = (bitpos == 8) ? 0 : bitpos + 1;
        end else if (prev_scl && !cur_scl) begin
            tgt_sda_low = 1'b0;
            if (bitpos == 8) begin
                if (byte_idx == 0)
                    tgt_sda_low = tgt_present && (shreg[7:1] == tgt_addr);
                else if (byte_idx == 1 && txn_match && !txn_rw)
                    tgt_sda_low = !tgt_nack_data;
            end else if (byte_idx == 1 && txn_match && txn_rw) begin
                tgt_sda_low = !tgt_rdata[3'(7 - bitpos)];
            end
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    function automatic logic [47:0] mon_sig();
        logic [47:0] s;
        s = '0;
        s[47:44] = 4'(n_start);
        s[43:40] = 4'(n_stop);
        s[39:36] = 4'(mon_bytes.size());
        for (int i = 0; i < mon_bytes.size() && i < 4; i++) s[i*9 +: 9] = {mon_bytes[i], mon_acks[i]};
        return s;
    endfunction

    function automatic logic [47:0] exp_sig();
        logic [47:0] s;
        s = '0;
        s[47:44] = 4'(exp_starts);
        s[43:40] = 4'(exp_starts);
        s[39:36] = 4'(exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < 4; i++) s[i*9 +: 9] = {exp_bytes[i], exp_acks[i]};
        return s;
    endfunction

    function automatic void model_clear();
        exp_bytes.delete();
        exp_acks.delete();
        exp_starts = 0;
    endfunction

    // One transaction as the bus should show it: address byte, then data byte only if addressed.
    function automatic void model_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                                      input logic present, input logic nack_data, input logic [7:0] rd);
        exp_starts++;
        exp_bytes.push_back({a, r});
        exp_acks.push_back(!present);
        exp_err = !present;
        if (present) begin
            exp_bytes.push_back(r ? rd : wd);
            exp_acks.push_back(r ? 1'b1 : nack_data);
            if (!r && nack_data) exp_err = 1'b1;
            if (r) exp_rdata = rd;
        end
    endfunction

    task automatic mon_clear();
        clr_gen++;
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           output int lat, output logic timeout);
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        bus_if.addr  = a;
        bus_if.rw    = r;
        bus_if.wdata = wd;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_if.done && lat < LIMIT);
        timeout = !bus_if.done;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.addr  = 7'h00;
        bus_if.rw    = 1'b0;
        bus_if.wdata = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus_if.busy); else n_pass++;
        n_checks++; if (bus_if.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus_if.done); else n_pass++;
        n_checks++; if (bus_if.ack_err !== 1'b0) $display("FAIL reset_ack_err: got %b want 0", bus_if.ack_err); else n_pass++;
        n_checks++; if (bus_if.rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", bus_if.rdata); else n_pass++;
        n_checks++; if (scl !== 1'b1 || sda !== 1'b1) $display("FAIL reset_lines: got scl=%b sda=%b want 1/1", scl, sda); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = 8'h00;
        repeat (5) @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) $display("FAIL post_reset_idle: got busy=%b done=%b want 0/0", bus_if.busy, bus_if.done); else n_pass++;
    endtask

    task automatic test_write();
        logic [6:0] a;
        logic [7:0] wd;
        int lat;
        logic to;
        for (int i = 0; i < 3; i++) begin
            a  = (i == 0) ? 7'h42 : 7'($urandom_range(127));
            wd = (i == 0) ? 8'hA5 : 8'($urandom_range(255));
            tgt_addr = a; tgt_present = 1'b1; tgt_nack_data = 1'b0;
            mon_clear(); model_clear();
            model_txn(a, 1'b0, wd, 1'b1, 1'b0, 8'h00);
            run_txn(a, 1'b0, wd, lat, to);
            n_checks++; if (to !== 1'b0) $display("FAIL write_timeout: done missing after %0d clks", lat); else n_pass++;
            n_checks++; if (mon_sig() !== exp_sig()) $display("FAIL write_bus: got %h want %h", mon_sig(), exp_sig()); else n_pass++;
            n_checks++; if (done_cnt !== 1) $display("FAIL write_done_count: got %0d want 1", done_cnt); else n_pass++;
            n_checks++; if (bus_if.ack_err !== 1'b0 || bus_if.rdata !== exp_rdata) $display("FAIL write_status: got err=%b rdata=%h want 0/%h", bus_if.ack_err, bus_if.rdata, exp_rdata); else n_pass++;
            n_checks++; if (lat < TXN_MIN || lat > TXN_MIN + SLACK) $display("FAIL write_latency: got %0d want %0d..%0d", lat, TXN_MIN, TXN_MIN + SLACK); else n_pass++;
        end
    endtask

    task automatic test_read();
        logic [6:0] a;
        logic [7:0] rd;
        int lat;
        logic to;
        for (int i = 0; i < 3; i++) begin
            a  = (i == 0) ? 7'h42 : 7'($urandom_range(127));
            rd = (i == 0) ? 8'h3C : 8'($urandom_range(255));
            tgt_addr = a; tgt_present = 1'b1; tgt_rdata = rd;
            mon_clear(); model_clear();
            model_txn(a, 1'b1, 8'h00, 1'b1, 1'b0, rd);
            run_txn(a, 1'b1, 8'($urandom_range(255)), lat, to);
            n_checks++; if (to !== 1'b0) $display("FAIL read_timeout: done missing after %0d clks", lat); else n_pass++;
            n_checks++; if (mon_sig() !== exp_sig()) $display("FAIL read_bus: got %h want %h", mon_sig(), exp_sig()); else n_pass++;
            n_checks++; if (bus_if.rdata !== exp_rdata) $display("FAIL read_rdata: got %h want %h", bus_if.rdata, exp_rdata); else n_pass++;
            n_checks++; if (bus_if.ack_err !== 1'b0 || done_cnt !== 1) $display("FAIL read_status: got err=%b dones=%0d want 0/1", bus_if.ack_err, done_cnt); else n_pass++;
        end
    endtask

    task automatic test_nack();
        logic [6:0] a;
        logic       r;
        logic [7:0] wd;
        int lat;
        logic to;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 7'h11 : 7'($urandom_range(127));
            r = (i == 0) ? 1'b1 : 1'($urandom_range(1));
            tgt_present = 1'b0;
            mon_clear(); model_clear();
            model_txn(a, r, 8'h00, 1'b0, 1'b0, 8'h00);
            run_txn(a, r, 8'h5A, lat, to);
            repeat (40) @(negedge clk);
            n_checks++; if (to !== 1'b0) $display("FAIL nack_timeout: done missing after %0d clks", lat); else n_pass++;
            n_checks++; if (mon_sig() !== exp_sig()) $display("FAIL nack_bus: got %h want %h", mon_sig(), exp_sig()); else n_pass++;
            n_checks++; if (bus_if.ack_err !== 1'b1 || bus_if.rdata !== exp_rdata) $display("FAIL nack_status: got err=%b rdata=%h want 1/%h", bus_if.ack_err, bus_if.rdata, exp_rdata); else n_pass++;
            n_checks++; if (lat < NACK_MIN || lat > NACK_MIN + SLACK) $display("FAIL nack_latency: got %0d want %0d..%0d", lat, NACK_MIN, NACK_MIN + SLACK); else n_pass++;
        end
        // Address ACKed, data byte NACKed.
        a = 7'($urandom_range(127)); wd = 8'($urandom_range(255));
        tgt_addr = a; tgt_present = 1'b1; tgt_nack_data = 1'b1;
        mon_clear(); model_clear();
        model_txn(a, 1'b0, wd, 1'b1, 1'b1, 8'h00);
        run_txn(a, 1'b0, wd, lat, to);
        tgt_nack_data = 1'b0;
        n_checks++; if (mon_sig() !== exp_sig() || to !== 1'b0) $display("FAIL data_nack_bus: got %h want %h timeout=%b", mon_sig(), exp_sig(), to); else n_pass++;
        n_checks++; if (bus_if.ack_err !== exp_err) $display("FAIL data_nack_err: got %b want %b", bus_if.ack_err, exp_err); else n_pass++;
    endtask

    task automatic test_stretch();
        logic [6:0] a;
        logic [7:0] wd;
        int lat, waited;
        logic to, found;
        a = 7'($urandom_range(127)); wd = 8'($urandom_range(255));
        tgt_addr = a; tgt_present = 1'b1;
        mon_clear(); model_clear();
        model_txn(a, 1'b0, wd, 1'b1, 1'b0, 8'h00);
        found = 1'b0;
        fork
            run_txn(a, 1'b0, wd, lat, to);
            begin
                waited = 0;
                while (!found && waited < LIMIT) begin
                    @(negedge clk); #1;
                    waited++;
                    if (byte_idx == 1 && bitpos == 3 && scl === 1'b0) found = 1'b1;
                end
                if (found) begin
                    tgt_scl_low = 1'b1;
                    repeat (500) @(negedge clk);
                    tgt_scl_low = 1'b0;
                end
            end
        join
        n_checks++; if (found !== 1'b1 || to !== 1'b0) $display("FAIL stretch_progress: got found=%b timeout=%b want 1/0", found, to); else n_pass++;
        n_checks++; if (mon_sig() !== exp_sig()) $display("FAIL stretch_bus: got %h want %h", mon_sig(), exp_sig()); else n_pass++;
        n_checks++; if (lat < TXN_MIN + 400 || lat > TXN_MIN + 500 + SLACK) $display("FAIL stretch_latency: got %0d want %0d..%0d", lat, TXN_MIN + 400, TXN_MIN + 500 + SLACK); else n_pass++;
    endtask

    task automatic test_mid_start();
        logic [6:0] a;
        logic [7:0] wd;
        int lat;
        logic to;
        a = 7'($urandom_range(127)); wd = 8'($urandom_range(255));
        tgt_addr = a; tgt_present = 1'b1;
        mon_clear(); model_clear();
        model_txn(a, 1'b0, wd, 1'b1, 1'b0, 8'h00);
        fork
            run_txn(a, 1'b0, wd, lat, to);
            begin
                repeat (6 * BIT_CLKS) @(posedge clk);
                #1;
                bus_if.start = 1'b1;
                bus_if.addr  = ~a;
                bus_if.rw    = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                bus_if.start = 1'b0;
            end
        join
        repeat (3 * BIT_CLKS) @(negedge clk);
        n_checks++; if (done_cnt !== 1 || to !== 1'b0) $display("FAIL mid_start_dones: got %0d timeout=%b want 1/0", done_cnt, to); else n_pass++;
        n_checks++; if (mon_sig() !== exp_sig()) $display("FAIL mid_start_bus: got %h want %h", mon_sig(), exp_sig()); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL mid_start_queued: got busy=%b want 0", bus_if.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] a;
        logic [7:0] wd1, wd2;
        int cyc;
        a = 7'($urandom_range(127)); wd1 = 8'($urandom_range(255)); wd2 = ~wd1;
        tgt_addr = a; tgt_present = 1'b1;
        mon_clear(); model_clear();
        model_txn(a, 1'b0, wd1, 1'b1, 1'b0, 8'h00);
        model_txn(a, 1'b0, wd2, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.addr = a; bus_if.rw = 1'b0; bus_if.wdata = wd1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus_if.done && cyc < LIMIT);
        bus_if.wdata = wd2;
        @(negedge clk);
        n_checks++; if (bus_if.busy !== 1'b1) $display("FAIL b2b_reaccept: got busy=%b want 1", bus_if.busy); else n_pass++;
        bus_if.start = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!bus_if.done && cyc < LIMIT);
        repeat (4) @(negedge clk);
        n_checks++; if (done_cnt !== 2) $display("FAIL b2b_dones: got %0d want 2", done_cnt); else n_pass++;
        n_checks++; if (mon_sig() !== exp_sig()) $display("FAIL b2b_bus: got %h want %h", mon_sig(), exp_sig()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] a;
        logic [7:0] rd;
        int lat;
        logic to;
        a = 7'($urandom_range(127)); rd = 8'($urandom_range(255));
        tgt_addr = a; tgt_present = 1'b1; tgt_rdata = rd;
        mon_clear();
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.addr = a; bus_if.rw = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (2 * BIT_CLKS + 5) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_rdata = 8'h00;
        #1;
        n_checks++; if (scl !== 1'b1 || sda !== 1'b1 || bus_if.busy !== 1'b0) $display("FAIL rst_mid_release: got scl=%b sda=%b busy=%b want 1/1/0", scl, sda, bus_if.busy); else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        n_checks++; if (done_cnt !== 0 || bus_if.rdata !== exp_rdata) $display("FAIL rst_mid_quiet: got dones=%0d rdata=%h want 0/%h", done_cnt, bus_if.rdata, exp_rdata); else n_pass++;
        mon_clear(); model_clear();
        model_txn(a, 1'b1, 8'h00, 1'b1, 1'b0, rd);
        run_txn(a, 1'b1, 8'h00, lat, to);
        n_checks++; if (mon_sig() !== exp_sig() || to !== 1'b0) $display("FAIL rst_mid_recover_bus: got %h want %h timeout=%b", mon_sig(), exp_sig(), to); else n_pass++;
        n_checks++; if (bus_if.rdata !== exp_rdata || done_cnt !== 1) $display("FAIL rst_mid_recover_rdata: got %h dones=%0d want %h/1", bus_if.rdata, done_cnt, exp_rdata); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_stretch();
        test_mid_start();
        test_back_to_back();
        test_reset_mid();
        n_checks++; if (overlap_cnt !== 0) $display("FAIL done_with_busy: got %0d cycles want 0", overlap_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
